reset_sequencer: RTL and testbench

Generates the staged, synchronously released reset outputs for downstream blocks from one board-level asynchronous reset. Internally performs asynchronous-assert / synchronous-release on the incoming reset. It then deasserts each downstream reset in order, from stage 0 upward. Each release waits a fixed delay, and each stage must acknowledge readiness before the next is released. A software reset request re-asserts the stages in reverse order and restarts the sequence.

---
 rtl/reset_sequencer.sv | 159 +++++++++++++++
 tb/tb_reset_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staged reset release: synchronises the board reset, then releases each downstream
// reset in turn after a fixed delay and a per-stage ready handshake.
module reset_sequencer #(
   parameter int N_STAGES      = 4,
   parameter int RELEASE_DELAY = 16,
   parameter int ACK_TIMEOUT   = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sw_rst_req,
   input  logic [N_STAGES-1:0] stage_ack,
   output logic [N_STAGES-1:0] rst_out,
   output logic                seq_done,
   output logic                timeout_err,
   output logic [3:0]          err_stage
);

   localparam int CNT_MAX = (RELEASE_DELAY > ACK_TIMEOUT) ? RELEASE_DELAY : ACK_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

   typedef enum logic [2:0] {
      HOLD,
      WAIT_DLY,
      WAIT_ACK,
      RUN,
      ERR,
      SHUTDOWN
   } state_t;

   logic [1:0]          rst_sync_reg;
   state_t              state_reg, state_next;
   logic [IDX_W-1:0]    idx_reg, idx_next;
   logic [CNT_W-1:0]    counter_reg, counter_next;
   logic [N_STAGES-1:0] rst_out_reg, rst_out_next;
   logic                seq_done_reg, seq_done_next;
   logic                timeout_err_reg, timeout_err_next;
   logic [3:0]          err_stage_reg, err_stage_next;
   logic [IDX_W-1:0]    hi_clear;
   logic                sw_accept;

   // Async set, release shifts a zero through both flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_sync_reg <= 2'b11;
      end else begin
         rst_sync_reg <= {rst_sync_reg[0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= HOLD;
         idx_reg         <= '0;
         counter_reg     <= '0;
         rst_out_reg     <= '1;
         seq_done_reg    <= 1'b0;
         timeout_err_reg <= 1'b0;
         err_stage_reg   <= 4'd0;
      end else begin
         state_reg       <= state_next;
         idx_reg         <= idx_next;
         counter_reg     <= counter_next;
         rst_out_reg     <= rst_out_next;
         seq_done_reg    <= seq_done_next;
         timeout_err_reg <= timeout_err_next;
         err_stage_reg   <= err_stage_next;
      end
   end

   // Released stages are always a contiguous low run, so the highest cleared bit
   // is the one to re-assert next during shutdown.
   always_comb begin
      hi_clear = '0;
      for (int i = 0; i < N_STAGES; i++) begin
         if (!rst_out_reg[i]) hi_clear = IDX_W'(i);
      end
   end

   assign sw_accept = sw_rst_req &&
                      ((state_reg == WAIT_DLY) || (state_reg == WAIT_ACK) ||
                       (state_reg == RUN)      || (state_reg == ERR));

   always_comb begin
      state_next       = state_reg;
      idx_next         = idx_reg;
      counter_next     = counter_reg;
      rst_out_next     = rst_out_reg;
      seq_done_next    = seq_done_reg;
      timeout_err_next = timeout_err_reg;
      err_stage_next   = err_stage_reg;

      if (sw_accept) begin
         seq_done_next    = 1'b0;
         timeout_err_next = 1'b0;
         err_stage_next   = 4'd0;
         counter_next     = '0;
         idx_next         = '0;
         state_next       = (&rst_out_reg) ? WAIT_DLY : SHUTDOWN;
      end else begin
         case (state_reg)
            HOLD: begin
               if (rst_sync_reg[1] && !rst_sync_reg[0]) begin
                  state_next   = WAIT_DLY;
                  counter_next = '0;
               end
            end
            WAIT_DLY: begin
               if (counter_reg == CNT_W'(RELEASE_DELAY - 1)) begin
                  rst_out_next[idx_reg] = 1'b0;
                  counter_next          = '0;
                  state_next            = WAIT_ACK;
               end else begin
                  counter_next = counter_reg + CNT_W'(1);
               end
            end
            WAIT_ACK: begin
               // An ack arriving on the timeout edge still counts.
               if (stage_ack[idx_reg]) begin
                  counter_next = '0;
                  if (idx_reg == IDX_W'(N_STAGES - 1)) begin
                     state_next    = RUN;
                     seq_done_next = 1'b1;
                  end else begin
                     idx_next   = idx_reg + IDX_W'(1);
                     state_next = WAIT_DLY;
                  end
               end else if (counter_reg == CNT_W'(ACK_TIMEOUT - 1)) begin
                  timeout_err_next = 1'b1;
                  err_stage_next   = 4'(idx_reg);
                  counter_next     = '0;
                  state_next       = ERR;
               end else begin
                  counter_next = counter_reg + CNT_W'(1);
               end
            end
            RUN, ERR: begin
            end
            SHUTDOWN: begin
               rst_out_next[hi_clear] = 1'b1;
               if (hi_clear == '0) begin
                  state_next   = WAIT_DLY;
                  idx_next     = '0;
                  counter_next = '0;
               end
            end
            default: begin
               state_next = HOLD;
            end
         endcase
      end
   end

   assign rst_out     = rst_out_reg;
   assign seq_done    = seq_done_reg;
   assign timeout_err = timeout_err_reg;
   assign err_stage   = err_stage_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with 4 stages, release delay 4, ack timeout 8.
module tb_reset_sequencer;

   logic       clk;
   logic       rst;
   logic       sw_rst_req;
   logic [3:0] stage_ack;
   logic [3:0] rst_out;
   logic       seq_done;
   logic       timeout_err;
   logic [3:0] err_stage;

   int checks;
   int errors;

   reset_sequencer #(
      .N_STAGES      (4),
      .RELEASE_DELAY (4),
      .ACK_TIMEOUT   (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sw_rst_req  (sw_rst_req),
      .stage_ack   (stage_ack),
      .rst_out     (rst_out),
      .seq_done    (seq_done),
      .timeout_err (timeout_err),
      .err_stage   (err_stage)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sw_rst_req = 1'b0;
      stage_ack = 4'b0000;
      repeat (2) tick();
      checks++;
      if (rst_out !== 4'b1111) begin errors++; $display("FAIL reset_rst_out got=%b exp=1111", rst_out); end
      checks++;
      if (seq_done !== 1'b0) begin errors++; $display("FAIL reset_seq_done got=%b exp=0", seq_done); end
      checks++;
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
      checks++;
      if (err_stage !== 4'd0) begin errors++; $display("FAIL reset_err_stage got=%0d exp=0", err_stage); end
      $display("test_reset done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_release();
      logic [3:0] exp;
      rst = 1'b0;
      repeat (5) tick();
      checks++;
      if (rst_out !== 4'b1111) begin errors++; $display("FAIL rel_edge5 got=%b exp=1111", rst_out); end
      for (int s = 0; s < 4; s++) begin
         tick();
         exp = 4'b1111 << (s + 1);
         checks++;
         if (rst_out !== exp) begin errors++; $display("FAIL rel_fall%0d got=%b exp=%b", s, rst_out, exp); end
         checks++;
         if (seq_done !== 1'b0) begin errors++; $display("FAIL rel_done_early%0d got=%b exp=0", s, seq_done); end
         stage_ack[s] = 1'b1;
         if (s < 3) begin
            repeat (4) begin
               tick();
               checks++;
               if (rst_out !== exp) begin errors++; $display("FAIL rel_hold%0d got=%b exp=%b", s, rst_out, exp); end
            end
         end
      end
      tick();
      checks++;
      if (seq_done !== 1'b1) begin errors++; $display("FAIL rel_done got=%b exp=1", seq_done); end
      checks++;
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL rel_timeout got=%b exp=0", timeout_err); end
      stage_ack = 4'b0000;
      repeat (3) tick();
      checks++;
      if (seq_done !== 1'b1 || rst_out !== 4'b0000) begin
         errors++; $display("FAIL run_ack_drop got=%b/%b exp=1/0000", seq_done, rst_out);
      end
      $display("test_release done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_sw_reset();
      logic [3:0] exp;
      sw_rst_req = 1'b1;
      tick();
      sw_rst_req = 1'b0;
      checks++;
      if (seq_done !== 1'b0) begin errors++; $display("FAIL sw_done_clr got=%b exp=0", seq_done); end
      checks++;
      if (rst_out !== 4'b0000) begin errors++; $display("FAIL sw_first_edge got=%b exp=0000", rst_out); end
      for (int k = 0; k < 4; k++) begin
         tick();
         exp = 4'b1111 << (3 - k);
         checks++;
         if (rst_out !== exp) begin errors++; $display("FAIL sw_shutdown%0d got=%b exp=%b", k, rst_out, exp); end
      end
      repeat (3) tick();
      checks++;
      if (rst_out !== 4'b1111) begin errors++; $display("FAIL sw_restart_hold got=%b exp=1111", rst_out); end
      tick();
      checks++;
      if (rst_out !== 4'b1110) begin errors++; $display("FAIL sw_restart_fall got=%b exp=1110", rst_out); end
      $display("test_sw_reset done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_async_reset();
      stage_ack = 4'b0001;
      tick();
      stage_ack = 4'b0000;
      repeat (4) tick();
      checks++;
      if (rst_out !== 4'b1100) begin errors++; $display("FAIL async_stage1 got=%b exp=1100", rst_out); end
      repeat (2) tick();
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (rst_out !== 4'b1111) begin errors++; $display("FAIL async_rst_out got=%b exp=1111", rst_out); end
      checks++;
      if (seq_done !== 1'b0 || timeout_err !== 1'b0) begin
         errors++; $display("FAIL async_flags got=%b/%b exp=0/0", seq_done, timeout_err);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) tick();
      checks++;
      if (rst_out !== 4'b1111) begin errors++; $display("FAIL async_rerelease_hold got=%b exp=1111", rst_out); end
      tick();
      checks++;
      if (rst_out !== 4'b1110) begin errors++; $display("FAIL async_rerelease_fall got=%b exp=1110", rst_out); end
      $display("test_async_reset done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_timeout();
      stage_ack = 4'b0011;
      tick();
      repeat (4) tick();
      checks++;
      if (rst_out !== 4'b1100) begin errors++; $display("FAIL to_stage1 got=%b exp=1100", rst_out); end
      tick();
      repeat (4) tick();
      checks++;
      if (rst_out !== 4'b1000) begin errors++; $display("FAIL to_stage2 got=%b exp=1000", rst_out); end
      for (int k = 1; k <= 8; k++) begin
         stage_ack[3] = k[0];
         tick();
         if (k < 8) begin
            checks++;
            if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early%0d got=%b exp=0", k, timeout_err); end
         end else begin
            checks++;
            if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag got=%b exp=1", timeout_err); end
            checks++;
            if (err_stage !== 4'd2) begin errors++; $display("FAIL to_err_stage got=%0d exp=2", err_stage); end
            checks++;
            if (rst_out !== 4'b1000) begin errors++; $display("FAIL to_rst_out got=%b exp=1000", rst_out); end
         end
      end
      stage_ack = 4'b1111;
      repeat (3) tick();
      checks++;
      if (timeout_err !== 1'b1 || rst_out !== 4'b1000 || seq_done !== 1'b0) begin
         errors++; $display("FAIL err_hold got=%b/%b/%b exp=1/1000/0", timeout_err, rst_out, seq_done);
      end
      $display("test_timeout done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_err_recover();
      stage_ack = 4'b0000;
      sw_rst_req = 1'b1;
      tick();
      sw_rst_req = 1'b0;
      checks++;
      if (timeout_err !== 1'b0 || err_stage !== 4'd0) begin
         errors++; $display("FAIL rec_clear got=%b/%0d exp=0/0", timeout_err, err_stage);
      end
      checks++;
      if (rst_out !== 4'b1000) begin errors++; $display("FAIL rec_first got=%b exp=1000", rst_out); end
      tick();
      checks++;
      if (rst_out !== 4'b1100) begin errors++; $display("FAIL rec_bit2 got=%b exp=1100", rst_out); end
      tick();
      checks++;
      if (rst_out !== 4'b1110) begin errors++; $display("FAIL rec_bit1 got=%b exp=1110", rst_out); end
      tick();
      checks++;
      if (rst_out !== 4'b1111) begin errors++; $display("FAIL rec_bit0 got=%b exp=1111", rst_out); end
      repeat (3) tick();
      checks++;
      if (rst_out !== 4'b1111) begin errors++; $display("FAIL rec_hold got=%b exp=1111", rst_out); end
      tick();
      checks++;
      if (rst_out !== 4'b1110) begin errors++; $display("FAIL rec_fall got=%b exp=1110", rst_out); end
      $display("test_err_recover done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_ack_race();
      stage_ack = 4'b0000;
      repeat (7) tick();
      checks++;
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL race_pre got=%b exp=0", timeout_err); end
      stage_ack[0] = 1'b1;
      tick();
      stage_ack = 4'b0000;
      checks++;
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL race_flag got=%b exp=0", timeout_err); end
      checks++;
      if (err_stage !== 4'd0) begin errors++; $display("FAIL race_err_stage got=%0d exp=0", err_stage); end
      repeat (3) tick();
      checks++;
      if (rst_out !== 4'b1110) begin errors++; $display("FAIL race_hold got=%b exp=1110", rst_out); end
      tick();
      checks++;
      if (rst_out !== 4'b1100 || timeout_err !== 1'b0) begin
         errors++; $display("FAIL race_advance got=%b/%b exp=1100/0", rst_out, timeout_err);
      end
      $display("test_ack_race done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_back_to_back();
      sw_rst_req = 1'b1;
      tick();
      checks++;
      if (rst_out !== 4'b1100) begin errors++; $display("FAIL b2b_accept got=%b exp=1100", rst_out); end
      tick();
      checks++;
      if (rst_out !== 4'b1110) begin errors++; $display("FAIL b2b_bit1 got=%b exp=1110", rst_out); end
      tick();
      checks++;
      if (rst_out !== 4'b1111) begin errors++; $display("FAIL b2b_bit0 got=%b exp=1111", rst_out); end
      sw_rst_req = 1'b0;
      repeat (2) tick();
      sw_rst_req = 1'b1;
      tick();
      sw_rst_req = 1'b0;
      repeat (3) tick();
      checks++;
      if (rst_out !== 4'b1111) begin errors++; $display("FAIL b2b_restart_hold got=%b exp=1111", rst_out); end
      tick();
      checks++;
      if (rst_out !== 4'b1110) begin errors++; $display("FAIL b2b_restart_fall got=%b exp=1110", rst_out); end
      $display("test_back_to_back done checks=%0d errors=%0d", checks, errors);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      sw_rst_req = 1'b0;
      stage_ack = 4'b0000;
      test_reset();
      test_release();
      test_sw_reset();
      test_async_reset();
      test_timeout();
      test_err_recover();
      test_ack_race();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
